// File: rtl/init_table_stream.sv
// RST cipher table builder: takes the key serially, flags repeated/invalid chars, fills interior rows.
// table_valid rises SIDE-1 cycles after the last key char; key_ready is low only while filling.
module init_table_stream #(
  parameter int SIDE             = 7,
  parameter bit CASE_INSENSITIVE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [7:0]             key_char,
  output logic                   key_ready,
  input  logic                   key_abort,
  output logic [SIDE*SIDE*8-1:0] sub_char,
  output logic                   table_valid,
  output logic                   busy,
  output logic                   err_repeated_char,
  output logic                   err_invalid_key_char
);
  localparam int M       = SIDE - 1;
  localparam int KEY_LEN = 2 * M;
  localparam int CW      = $clog2(KEY_LEN + 1);
  localparam int RW      = $clog2(SIDE + 1);
  localparam int TW      = SIDE * SIDE * 8;

  function automatic logic [TW-1:0] build_interior();
    logic [TW-1:0] t;
    int i;
    t = '0;
    for (int r = 1; r <= M; r++) begin
      for (int c = 1; c <= M; c++) begin
        i = ((r - 1) * M + (c - 1)) % 36;
        t[8*(r*SIDE+c) +: 8] = (i < 26) ? 8'(97 + i) : 8'(48 + i - 26);
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] INTERIOR = build_interior();

  typedef enum logic [1:0] {ST_LOAD, ST_FILL, ST_DONE, ST_ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [RW-1:0] row_q;
  logic [127:0]  seen_q;
  logic          accept, restart, last, is_alnum, hit, rep_d, inv_d;
  logic [7:0]    x_fold;
  int            n, hdr_pos;

  always_comb begin
    key_ready = (state_q != ST_FILL);
    busy      = (state_q == ST_LOAD && count_q != '0) || (state_q == ST_FILL);
    accept    = key_valid && key_ready && !key_abort;
    restart   = accept && (state_q == ST_DONE || state_q == ST_ERR);
    last      = accept && !restart && (count_q == CW'(KEY_LEN - 1));
    is_alnum  = (key_char >= 8'h30 && key_char <= 8'h39) ||
                (key_char >= 8'h41 && key_char <= 8'h5a) ||
                (key_char >= 8'h61 && key_char <= 8'h7a);
    x_fold = key_char;
    if (CASE_INSENSITIVE && key_char >= 8'h41 && key_char <= 8'h5a) x_fold = key_char | 8'h20;
    // A restarting key starts from an empty history, so nothing can repeat yet.
    hit   = !key_char[7] && !restart && seen_q[x_fold[6:0]];
    rep_d = (err_repeated_char && !restart) || hit;
    inv_d = (err_invalid_key_char && !restart) || !is_alnum;
    n     = restart ? 0 : int'(count_q);
    if (n[0] == 1'b0) hdr_pos = (((n / 2) < (M / 2)) ? n + 1 : 2 * M - n) * SIDE;
    else              hdr_pos = (n < M) ? n : 2 * M + 1 - n;

    state_d = state_q;
    if (key_abort) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: if (last) state_d = (rep_d || inv_d) ? ST_ERR : ST_FILL;
        ST_FILL: if (row_q == RW'(M)) state_d = ST_DONE;
        default: if (accept) state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q              <= '0;
      row_q                <= '0;
      seen_q               <= '0;
      sub_char             <= '0;
      table_valid          <= 1'b0;
      err_repeated_char    <= 1'b0;
      err_invalid_key_char <= 1'b0;
    end else if (key_abort) begin
      count_q              <= '0;
      seen_q               <= '0;
      sub_char             <= '0;
      table_valid          <= 1'b0;
      err_repeated_char    <= 1'b0;
      err_invalid_key_char <= 1'b0;
    end else if (accept) begin
      if (restart) begin
        sub_char    <= '0;
        seen_q      <= '0;
        table_valid <= 1'b0;
      end
      if (last && (rep_d || inv_d)) sub_char <= '0;
      else                          sub_char[8*hdr_pos +: 8] <= key_char;
      if (!key_char[7]) seen_q[x_fold[6:0]] <= 1'b1;
      err_repeated_char    <= rep_d;
      err_invalid_key_char <= inv_d;
      count_q <= restart ? CW'(1) : count_q + 1'b1;
      row_q   <= RW'(1);
    end else if (state_q == ST_FILL) begin
      for (int c = 1; c <= M; c++) begin
        sub_char[8*(int'(row_q)*SIDE+c) +: 8] <= INTERIOR[8*(int'(row_q)*SIDE+c) +: 8];
      end
      row_q <= row_q + 1'b1;
      if (row_q == RW'(M)) table_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_init_table_stream.sv
// Bench for init_table_stream: key vector table, spot cells, abort/reset sequences and random
// keys checked against a reference model of the table layout and duplicate/charset rules.
module tb_init_table_stream;
  localparam int TW = 392;

  logic       clk = 1'b0;
  logic       rst, kv, abort;
  logic [7:0] kc;
  int         sel;

  logic [2:0]    rdy, tv, bsy, rep, inv;
  logic [391:0]  sc0, sc1;
  logic [199:0]  sc2;
  logic [TW-1:0] c_sc;
  logic          c_rdy, c_tv, c_busy, c_rep, c_inv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  init_table_stream #(.SIDE(7), .CASE_INSENSITIVE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 0), .key_char(kc), .key_ready(rdy[0]),
    .key_abort(abort && sel == 0), .sub_char(sc0), .table_valid(tv[0]), .busy(bsy[0]),
    .err_repeated_char(rep[0]), .err_invalid_key_char(inv[0]));

  init_table_stream #(.SIDE(7), .CASE_INSENSITIVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 1), .key_char(kc), .key_ready(rdy[1]),
    .key_abort(abort && sel == 1), .sub_char(sc1), .table_valid(tv[1]), .busy(bsy[1]),
    .err_repeated_char(rep[1]), .err_invalid_key_char(inv[1]));

  init_table_stream #(.SIDE(5), .CASE_INSENSITIVE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 2), .key_char(kc), .key_ready(rdy[2]),
    .key_abort(abort && sel == 2), .sub_char(sc2), .table_valid(tv[2]), .busy(bsy[2]),
    .err_repeated_char(rep[2]), .err_invalid_key_char(inv[2]));

  always_comb begin
    c_sc   = (sel == 0) ? sc0 : (sel == 1) ? sc1 : {192'b0, sc2};
    c_rdy  = rdy[sel];
    c_tv   = tv[sel];
    c_busy = bsy[sel];
    c_rep  = rep[sel];
    c_inv  = inv[sel];
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] kch(input logic [95:0] k, input int len, input int n);
    return k[8*(len-1-n) +: 8];
  endfunction

  function automatic bit alnum(input logic [7:0] a);
    return (a >= "0" && a <= "9") || (a >= "A" && a <= "Z") || (a >= "a" && a <= "z");
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] a, input bit ci);
    return (ci && a >= "A" && a <= "Z") ? a + 8'd32 : a;
  endfunction

  // Row r of column 0 / column c of row 0: odd positions come from the front of the key,
  // even positions from the back, interleaved.
  function automatic logic [TW-1:0] model_table(input logic [95:0] k, input int side);
    string alpha;
    int m, len, idx;
    logic [TW-1:0] t;
    alpha = "abcdefghijklmnopqrstuvwxyz0123456789";
    m = side - 1; len = 2 * m; t = '0; idx = 0;
    for (int r = 1; r <= m; r++) begin
      t[8*(r*side) +: 8] = (r % 2 == 1) ? kch(k, len, r - 1) : kch(k, len, 2 * m - r);
      t[8*r +: 8]        = (r % 2 == 1) ? kch(k, len, r)     : kch(k, len, 2 * m + 1 - r);
      for (int c = 1; c <= m; c++) begin
        t[8*(r*side+c) +: 8] = alpha.getc(idx % 36);
        idx++;
      end
    end
    return t;
  endfunction

  function automatic logic [1:0] model_flags(input logic [95:0] k, input int len, input int upto,
                                             input bit ci);
    logic r, v;
    logic [7:0] a, b;
    r = 1'b0; v = 1'b0;
    for (int n = 0; n <= upto; n++) begin
      a = kch(k, len, n);
      if (!alnum(a)) v = 1'b1;
      for (int p = 0; p < n; p++) begin
        b = kch(k, len, p);
        if (!a[7] && !b[7] && fold(a, ci) == fold(b, ci)) r = 1'b1;
      end
    end
    return {r, v};
  endfunction

  // ---------------- check and drive helpers ----------------
  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beats(input logic [95:0] k, input int len, input int from, input int to,
                            input bit gaps);
    logic [1:0] f;
    for (int n = from; n <= to; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); kv = 1'b0; end
      @(negedge clk); kv = 1'b1; kc = kch(k, len, n);
      @(posedge clk); #1;
      f = model_flags(k, len, n, sel == 1);
      chk($sformatf("beat%0d_rep", n), TW'(c_rep), TW'(f[1]));
      chk($sformatf("beat%0d_inv", n), TW'(c_inv), TW'(f[0]));
      if (n < len - 1) chk($sformatf("beat%0d_busy", n), TW'(c_busy), TW'(1));
    end
  endtask

  task automatic run_key(input string name, input logic [95:0] k, input int side, input bit gaps,
                         input bit ev, input bit er, input bit ei);
    int m, len, lat;
    m = side - 1; len = 2 * m; lat = -1;
    send_beats(k, len, 0, len - 1, gaps);
    chk({name, "_busy_end"}, TW'(c_busy), TW'(ev));
    for (int e = 0; e <= m + 3; e++) begin
      @(negedge clk); kv = 1'b0;
      if (c_tv) begin lat = e; break; end
      if (ev && e < m) chk({name, "_ready_fill"}, TW'(c_rdy), TW'(0));
    end
    chk({name, "_latency"}, TW'(lat), ev ? TW'(m) : TW'(-1));
    chk({name, "_rep"}, TW'(c_rep), TW'(er));
    chk({name, "_inv"}, TW'(c_inv), TW'(ei));
    chk({name, "_table"}, c_sc, ev ? model_table(k, side) : '0);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [95:0] key;
    logic [1:0]  dut;
    logic        gaps;
    logic        ev;
    logic        er;
    logic        ei;
  } vec_t;

  typedef struct packed {
    logic [2:0] vec;
    logic [3:0] r;
    logic [3:0] c;
    logic [7:0] ch;
  } spot_t;

  vec_t  vecs[7];
  spot_t spots[18];

  logic [95:0] rk;
  logic [1:0]  rf;
  int          side, len, rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; kv = 1'b0; kc = 8'h00; abort = 1'b0; sel = 0;

    vecs[0] = '{key: "abcdefghilmn", dut: 2'd0, gaps: 1'b0, ev: 1'b1, er: 1'b0, ei: 1'b0};
    vecs[1] = '{key: "abcdeaghilmn", dut: 2'd0, gaps: 1'b0, ev: 1'b0, er: 1'b1, ei: 1'b0};
    vecs[2] = '{key: "abc#efghilmn", dut: 2'd0, gaps: 1'b0, ev: 1'b0, er: 1'b0, ei: 1'b1};
    vecs[3] = '{key: "aBcdefghilmA", dut: 2'd1, gaps: 1'b0, ev: 1'b0, er: 1'b1, ei: 1'b0};
    vecs[4] = '{key: "aBcdefghilmA", dut: 2'd0, gaps: 1'b0, ev: 1'b1, er: 1'b0, ei: 1'b0};
    vecs[5] = '{key: "pqrstuvw",     dut: 2'd2, gaps: 1'b0, ev: 1'b1, er: 1'b0, ei: 1'b0};
    vecs[6] = '{key: "abcdefghilmn", dut: 2'd0, gaps: 1'b1, ev: 1'b1, er: 1'b0, ei: 1'b0};

    spots[0]  = '{vec: 3'd0, r: 4'd1, c: 4'd0, ch: "a"};
    spots[1]  = '{vec: 3'd0, r: 4'd2, c: 4'd0, ch: "m"};
    spots[2]  = '{vec: 3'd0, r: 4'd0, c: 4'd2, ch: "n"};
    spots[3]  = '{vec: 3'd0, r: 4'd0, c: 4'd6, ch: "h"};
    spots[4]  = '{vec: 3'd0, r: 4'd1, c: 4'd1, ch: "a"};
    spots[5]  = '{vec: 3'd0, r: 4'd5, c: 4'd3, ch: "0"};
    spots[6]  = '{vec: 3'd0, r: 4'd6, c: 4'd6, ch: "9"};
    spots[7]  = '{vec: 3'd0, r: 4'd0, c: 4'd0, ch: 8'h00};
    spots[8]  = '{vec: 3'd5, r: 4'd1, c: 4'd0, ch: "p"};
    spots[9]  = '{vec: 3'd5, r: 4'd2, c: 4'd0, ch: "v"};
    spots[10] = '{vec: 3'd5, r: 4'd3, c: 4'd0, ch: "r"};
    spots[11] = '{vec: 3'd5, r: 4'd4, c: 4'd0, ch: "t"};
    spots[12] = '{vec: 3'd5, r: 4'd0, c: 4'd1, ch: "q"};
    spots[13] = '{vec: 3'd5, r: 4'd0, c: 4'd2, ch: "w"};
    spots[14] = '{vec: 3'd5, r: 4'd0, c: 4'd3, ch: "s"};
    spots[15] = '{vec: 3'd5, r: 4'd0, c: 4'd4, ch: "u"};
    spots[16] = '{vec: 3'd5, r: 4'd1, c: 4'd1, ch: "a"};
    spots[17] = '{vec: 3'd5, r: 4'd4, c: 4'd4, ch: "p"};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      chk($sformatf("rst%0d_ready", d), TW'(c_rdy), TW'(1));
      chk($sformatf("rst%0d_tv", d), TW'(c_tv), TW'(0));
      chk($sformatf("rst%0d_busy", d), TW'(c_busy), TW'(0));
      chk($sformatf("rst%0d_flags", d), TW'({c_rep, c_inv}), TW'(0));
      chk($sformatf("rst%0d_table", d), c_sc, '0);
    end
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sel  = int'(vecs[i].dut);
      side = (sel == 2) ? 5 : 7;
      run_key($sformatf("vec%0d", i), vecs[i].key, side, vecs[i].gaps,
              vecs[i].ev, vecs[i].er, vecs[i].ei);
      for (int s = 0; s < 18; s++) begin
        if (int'(spots[s].vec) == i)
          chk($sformatf("vec%0d_cell_%0d_%0d", i, spots[s].r, spots[s].c),
              TW'(c_sc[8*(int'(spots[s].r)*side+int'(spots[s].c)) +: 8]), TW'(spots[s].ch));
      end
    end

    // Abort on beat 7 of a key that already has both flags raised.
    sel = 0;
    send_beats("a#aaaaaaaaaa", 12, 0, 6, 1'b0);
    @(negedge clk); kv = 1'b1; kc = "a"; abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", TW'(c_busy), TW'(0));
    chk("abort_flags", TW'({c_rep, c_inv}), TW'(0));
    chk("abort_tv", TW'(c_tv), TW'(0));
    chk("abort_table", c_sc, '0);
    @(negedge clk); abort = 1'b0; kv = 1'b0;
    run_key("after_abort", "zyxwvu987654", 7, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset pulse while the interior rows are being filled.
    send_beats("abcdefghilmn", 12, 0, 11, 1'b0);
    @(negedge clk); kv = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("rstfill_tv", TW'(c_tv), TW'(0));
    chk("rstfill_table", c_sc, '0);
    chk("rstfill_busy", TW'(c_busy), TW'(0));
    chk("rstfill_ready", TW'(c_rdy), TW'(1));
    chk("rstfill_flags", TW'({c_rep, c_inv}), TW'(0));
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstfill_tv_later", TW'(c_tv), TW'(0));
    chk("rstfill_table_later", c_sc, '0);

    // Random keys across all three configurations.
    for (int t = 0; t < 24; t++) begin
      sel  = t % 3;
      side = (sel == 2) ? 5 : 7;
      len  = 2 * (side - 1);
      rk   = '0;
      for (int n = 0; n < len; n++) begin
        rv = $urandom_range(0, 65);
        rk[8*(len-1-n) +: 8] = (rv < 10) ? 8'(48 + rv) :
                               (rv < 36) ? 8'(97 + rv - 10) :
                               (rv < 62) ? 8'(65 + rv - 36) :
                               (rv < 64) ? 8'h23 : 8'h2d;
      end
      rf = model_flags(rk, len, len - 1, sel == 1);
      run_key($sformatf("rnd%0d", t), rk, side, 1'($urandom_range(0, 1)),
              !(rf[1] || rf[0]), rf[1], rf[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
